// File: rtl/mac_dot_engine_if.sv
// Stream-side bundle for mac_dot_engine: operand beats in, dot-product results out.
// master = beat source / result consumer; slave = the engine.
interface mac_dot_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 72
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic                    signed_mode;
  logic [LANES*DATA_W-1:0] ain;
  logic [LANES*DATA_W-1:0] bin;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        dout;
  logic [15:0]             out_count;

  modport master (
    output in_valid, in_last, signed_mode, ain, bin, out_ready,
    input  in_ready, out_valid, dout, out_count
  );

  modport slave (
    input  in_valid, in_last, signed_mode, ain, bin, out_ready,
    output in_ready, out_valid, dout, out_count
  );
endinterface

// File: rtl/mac_dot_engine.sv
// LANES-wide dot-product accumulator: multiply, adder tree and accumulate stages,
// one result per vector delimited by in_last.
module mac_dot_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 72
) (
  input logic             clk,
  input logic             rstn,
  mac_dot_engine_if.slave bus
);
  localparam int unsigned PW = 2 * (DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

  state_e state_q, state_d;
  logic   accept;
  logic   mode_q, mode_eff;
  logic [15:0] count_q;

  logic signed [DATA_W:0] a_x [LANES];
  logic signed [DATA_W:0] b_x [LANES];
  logic signed [PW-1:0]   p_x [LANES];
  logic [ACC_W-1:0]       prod_d [LANES];
  logic [ACC_W-1:0]       prod_q [LANES];
  logic [ACC_W-1:0]       sum_d, sum_q, acc_q, dout_q;
  logic [15:0]            out_count_q;

  logic s1_valid_q, s1_last_q, s1_first_q;
  logic s2_valid_q, s2_last_q, s2_first_q;
  logic acc_last_q;

  assign accept = bus.in_valid && bus.in_ready;
  // The first beat is multiplied in the same cycle its mode is latched.
  assign mode_eff = (state_q == StIdle) ? bus.signed_mode : mode_q;

  // Operands widened by one bit so both modes share one signed multiplier.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      a_x[k]    = {mode_eff & bus.ain[k*DATA_W+DATA_W-1], bus.ain[k*DATA_W +: DATA_W]};
      b_x[k]    = {mode_eff & bus.bin[k*DATA_W+DATA_W-1], bus.bin[k*DATA_W +: DATA_W]};
      p_x[k]    = PW'(a_x[k]) * PW'(b_x[k]);
      prod_d[k] = ACC_W'(p_x[k]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      sum_d = sum_d + prod_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = bus.in_last ? StDrain : StAccum;
      StAccum: if (accept && bus.in_last) state_d = StDrain;
      StDrain: if (acc_last_q) state_d = StHold;
      StHold:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      count_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_first_q  <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      acc_last_q  <= 1'b0;
      dout_q      <= '0;
      out_count_q <= '0;
      for (int k = 0; k < int'(LANES); k++) prod_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == StIdle) mode_q <= bus.signed_mode;
      if (accept) begin
        if (state_q == StIdle)         count_q <= 16'd1;
        else if (count_q != 16'hFFFF)  count_q <= count_q + 16'd1;
      end

      s1_valid_q <= accept;
      s1_last_q  <= accept && bus.in_last;
      s1_first_q <= state_q == StIdle;
      if (accept) begin
        for (int k = 0; k < int'(LANES); k++) prod_q[k] <= prod_d[k];
      end

      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_valid_q && s1_last_q;
      s2_first_q <= s1_first_q;
      if (s1_valid_q) sum_q <= sum_d;

      // First beat of a vector overwrites rather than adds, clearing the accumulator.
      if (s2_valid_q) acc_q <= s2_first_q ? sum_q : acc_q + sum_q;
      acc_last_q <= s2_valid_q && s2_last_q;

      if (state_q == StDrain && acc_last_q) begin
        dout_q      <= acc_q;
        out_count_q <= count_q;
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle) || (state_q == StAccum);
  assign bus.out_valid = state_q == StHold;
  assign bus.dout      = dout_q;
  assign bus.out_count = out_count_q;
endmodule

// File: doc/mac_dot_engine.md
Name: mac_dot_engine

Overview:
- Parametrised successor to the scalar 32x32->64 MAC.
- Computes a LANES-wide dot product per accepted beat and accumulates beats until in_last, then presents one result.
- Pipelined in three stages (multiply, adder tree, accumulate), with valid/ready on both sides and a per-vector signed/unsigned mode.
- Inner-product engine feeding the matrix-multiplication datapath.

Parameters:
DATA_W, 32, operand width per lane
LANES, 4, operand pairs per beat (power of two, 1..16)
ACC_W, 72, accumulator/result width (>= 2*DATA_W + log2(LANES))

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
in_valid  in  1  beat valid
in_ready  out  1  engine accepts beat
in_last  in  1  final beat of vector (qualified by in_valid)
signed_mode  in  1  1 = two's-complement operands; sampled on first beat of vector
ain  in  LANES*DATA_W  lane k = ain[k*DATA_W +: DATA_W]
bin  in  LANES*DATA_W  lane k = bin[k*DATA_W +: DATA_W]
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
dout  out  ACC_W  accumulated dot product
out_count  out  16  beats in vector, saturating at 0xFFFF

Behaviour:
- Reset (rstn=0 at a rising edge):
  - State -> IDLE; out_valid=0, dout=0, out_count=0, in_ready=1.
  - Pipeline valids, accumulator and beat counter cleared.
  - Any in-flight vector is discarded; no partial result is emitted.
- A beat is accepted on any edge with in_valid && in_ready. Beats with in_ready=0 are ignored.
- States:
  - IDLE: in_ready=1. On first accepted beat: latch signed_mode, clear accumulator, set count=1. Go to ACCUM, or to DRAIN if in_last.
  - ACCUM: in_ready=1. Each accepted beat increments count (saturating). An accepted in_last goes to DRAIN.
  - DRAIN: in_ready=0. Waits until the last beat exits the accumulate stage, then goes to HOLD with out_valid=1.
  - HOLD: in_ready=0; dout and out_count stable. out_valid && out_ready -> IDLE with out_valid=0; in_ready rises the next cycle.
- Latency:
  - Last beat accepted at edge E -> out_valid=1 after edge E+3.
  - Stage 1 registers LANES products; stage 2 registers the tree sum; stage 3 accumulates; E+3 transitions DRAIN->HOLD.
- Throughput: one beat per cycle within a vector. Minimum 4-cycle gap between a vector's last beat and the next vector's first beat.
- Arithmetic:
  - signed_mode=1: operands sign-extended, products are signed 2*DATA_W.
  - signed_mode=0: operands zero-extended.
  - Products and sum are extended to ACC_W per mode. Accumulation wraps modulo 2^ACC_W with no saturation flag.
- signed_mode changes mid-vector are ignored. The latched value holds until IDLE.
- Single-beat vector (first beat has in_last=1) is legal: count=1.
- out_ready without out_valid has no effect.
- in_valid without in_last in DRAIN/HOLD is not accepted; the source must hold it.

Test Plan:
- Single beat, unsigned: ain lanes {1,2,3,4}, bin {5,6,7,8}, in_last=1 -> out_valid 3 cycles later, dout=70, out_count=1.
- Mode: lane0 a=0xFFFFFFFF b=3, lane1 a=2 b=4, other lanes 0.
  - signed_mode=1 -> dout=5.
  - signed_mode=0 -> dout=0x300000005.
- 31-beat vector, back-to-back: lane0 a=i, b=i+1 for i=0..30, other lanes 0, in_last on i=30 -> dout=9920, out_count=31. in_ready=1 throughout ACCUM.
- Max unsigned: all lanes a=b=0xFFFFFFFF, one beat -> dout=0x3FFFFFFF800000004 (no wrap at ACC_W=72).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> dout/out_count stable, in_ready=0, offered beats not accepted. Raise out_ready -> out_valid falls next edge, in_ready=1 the following cycle. Next vector {1,1,1,1}·{1,1,1,1} -> dout=4.
- Reset mid-op: rstn=0 for one edge in ACCUM and again in DRAIN -> no out_valid pulse, out_count=0, dout=0. Next vector computes from a cleared accumulator.
